// File: rtl/ariane_regfile_pkg.sv
// ariane_regfile_pkg
// Shared types and helpers for the scoreboarded flip-flop register file.
//   NR_REGS_DEFAULT    : default architectural register count
//   ADDR_WIDTH_DEFAULT : register index width for the default register count
//   regaddr_t          : register index type for the default register count
//   clog2_cnt(n)       : bits needed to hold any count in 0..n
package ariane_regfile_pkg;

  localparam int unsigned NR_REGS_DEFAULT    = 32'd32;
  localparam int unsigned ADDR_WIDTH_DEFAULT = $clog2(NR_REGS_DEFAULT);

  typedef logic [ADDR_WIDTH_DEFAULT-1:0] regaddr_t;

  // Width of a counter that must represent every value from 0 up to n
  // inclusive. For n = 32 this gives 6 bits, not the 5 that $clog2(32) gives.
  function automatic int unsigned clog2_cnt(input int unsigned n);
    int unsigned w;
    w = 32'd1;
    for (int unsigned i = 32'd1; i < 32'd32; i++) begin
      if ((32'd1 << i) <= n) begin
        w = i + 32'd1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/ariane_regfile_wr_arb.sv
// ariane_regfile_wr_arb
// Per-register priority select over the writeback ports. For each
// architectural register, the highest-indexed enabled port that targets it
// supplies the data. Register 0 is masked out when it is hardwired to zero.
//   waddr_i     : writeback addresses, one per port
//   wdata_i     : writeback data, one per port
//   we_i        : writeback enables, one per port
//   reg_we_o    : per-register write enable after masking
//   reg_wdata_o : per-register selected data
//   conflict_o  : two or more enabled ports hit the same non-masked register
module ariane_regfile_wr_arb
  import ariane_regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32'd64,
  parameter int unsigned NR_REGS        = NR_REGS_DEFAULT,
  parameter int unsigned NR_WRITE_PORTS = 32'd2,
  parameter int unsigned ZERO_REG_ZERO  = 32'd1,
  parameter int unsigned ADDR_WIDTH     = $clog2(NR_REGS)
) (
  input  logic [NR_WRITE_PORTS-1:0][ADDR_WIDTH-1:0] waddr_i,
  input  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wdata_i,
  input  logic [NR_WRITE_PORTS-1:0]                 we_i,
  output logic [NR_REGS-1:0]                        reg_we_o,
  output logic [NR_REGS-1:0][DATA_WIDTH-1:0]        reg_wdata_o,
  output logic                                      conflict_o
);

  logic [NR_REGS-1:0] conflict_vec_s;

  for (genvar r = 0; r < NR_REGS; r++) begin : g_reg
    // Register 0 writes vanish entirely when it is hardwired, including from
    // conflict detection.
    localparam bit DROP_REG = (ZERO_REG_ZERO != 32'd0) && (r == 32'sd0);

    logic                  hit_s;
    logic                  multi_s;
    logic [DATA_WIDTH-1:0] data_s;

    // Ascending scan so a later (higher-priority) port overrides the pick.
    always_comb begin
      hit_s   = 1'b0;
      multi_s = 1'b0;
      data_s  = '0;
      for (int j = 0; j < NR_WRITE_PORTS; j++) begin
        if (we_i[j] && (waddr_i[j] == ADDR_WIDTH'(r))) begin
          multi_s = multi_s | hit_s;
          hit_s   = 1'b1;
          data_s  = wdata_i[j];
        end else begin
          hit_s   = hit_s;
        end
      end
    end

    assign reg_we_o[r]       = hit_s & ~DROP_REG;
    assign reg_wdata_o[r]    = data_s;
    assign conflict_vec_s[r] = multi_s & ~DROP_REG;
  end

  assign conflict_o = |conflict_vec_s;

endmodule

// File: rtl/ariane_regfile_sb.sv
// ariane_regfile_sb
// Parametrised flip-flop register file with a per-register pending
// (scoreboard) bit. Issue marks a destination pending through the allocation
// handshake; writeback stores data and clears the bit.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding).
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   flush_i        : clear every pending bit at the next edge
//   raddr_i        : read addresses (combinational read ports)
//   rdata_o        : read data
//   rready_o       : operand is not pending
//   alloc_valid_i  : issue wants to mark alloc_addr_i pending
//   alloc_addr_i   : destination register to allocate
//   alloc_ready_o  : allocation would be accepted this cycle
//   waddr_i, wdata_i, we_i : writeback ports, higher index wins
//   pending_cnt_o  : registered number of pending registers
//   wr_conflict_o  : registered pulse, same-address multi-port write last cycle
module ariane_regfile_sb
  import ariane_regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32'd64,
  parameter int unsigned NR_REGS        = NR_REGS_DEFAULT,
  parameter int unsigned NR_READ_PORTS  = 32'd2,
  parameter int unsigned NR_WRITE_PORTS = 32'd2,
  parameter int unsigned ZERO_REG_ZERO  = 32'd1,
  parameter int unsigned ADDR_WIDTH     = $clog2(NR_REGS)
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      flush_i,
  input  logic [NR_READ_PORTS-1:0][ADDR_WIDTH-1:0]  raddr_i,
  output logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]  rdata_o,
  output logic [NR_READ_PORTS-1:0]                  rready_o,
  input  logic                                      alloc_valid_i,
  input  logic [ADDR_WIDTH-1:0]                     alloc_addr_i,
  output logic                                      alloc_ready_o,
  input  logic [NR_WRITE_PORTS-1:0][ADDR_WIDTH-1:0] waddr_i,
  input  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wdata_i,
  input  logic [NR_WRITE_PORTS-1:0]                 we_i,
  output logic [clog2_cnt(NR_REGS)-1:0]             pending_cnt_o,
  output logic                                      wr_conflict_o
);

  localparam int unsigned CNT_WIDTH = clog2_cnt(NR_REGS);
  localparam bit          ZERO_EN   = (ZERO_REG_ZERO != 32'd0);

  logic [DATA_WIDTH-1:0]              mem_r [NR_REGS];
  logic [NR_REGS-1:0]                 pending_r;
  logic [NR_REGS-1:0]                 pending_nxt_s;
  logic [CNT_WIDTH-1:0]               pending_cnt_r;
  logic [CNT_WIDTH-1:0]               cnt_nxt_s;
  logic                               wr_conflict_r;
  logic [NR_REGS-1:0]                 reg_we_s;
  logic [NR_REGS-1:0][DATA_WIDTH-1:0] reg_wdata_s;
  logic                               conflict_s;
  logic                               alloc_ready_s;
  logic                               alloc_fire_s;
  logic                               alloc_is_zero_s;

  ariane_regfile_wr_arb #(
    .DATA_WIDTH     (DATA_WIDTH),
    .NR_REGS        (NR_REGS),
    .NR_WRITE_PORTS (NR_WRITE_PORTS),
    .ZERO_REG_ZERO  (ZERO_REG_ZERO),
    .ADDR_WIDTH     (ADDR_WIDTH)
  ) u_wr_arb (
    .waddr_i     (waddr_i),
    .wdata_i     (wdata_i),
    .we_i        (we_i),
    .reg_we_o    (reg_we_s),
    .reg_wdata_o (reg_wdata_s),
    .conflict_o  (conflict_s)
  );

  assign alloc_is_zero_s = ZERO_EN && (alloc_addr_i == '0);

  // Allocation readiness looks only at the current pending bit, so a
  // writeback landing this cycle does not unblock a same-register allocation
  // until the following cycle.
  always_comb begin
    if (alloc_is_zero_s) begin
      alloc_ready_s = 1'b1;
    end else begin
      alloc_ready_s = ~pending_r[alloc_addr_i];
    end
  end

  assign alloc_ready_o = alloc_ready_s;
  assign alloc_fire_s  = alloc_valid_i && alloc_ready_s && !flush_i;

  // Next pending vector: writes clear, then a new allocation sets, so a
  // same-cycle write and allocation leave the new producer pending.
  always_comb begin
    pending_nxt_s = pending_r;
    if (flush_i) begin
      pending_nxt_s = '0;
    end else begin
      pending_nxt_s = pending_r & ~reg_we_s;
      if (alloc_fire_s && !alloc_is_zero_s) begin
        pending_nxt_s[alloc_addr_i] = 1'b1;
      end else begin
        pending_nxt_s = pending_nxt_s;
      end
    end
  end

  // Popcount of the next pending vector, registered alongside it.
  always_comb begin
    cnt_nxt_s = '0;
    for (int unsigned r = 32'd0; r < NR_REGS; r++) begin
      cnt_nxt_s = cnt_nxt_s + CNT_WIDTH'(pending_nxt_s[r]);
    end
  end

  // Combinational read ports with optional same-cycle writeback forwarding.
  always_comb begin
    rdata_o  = '0;
    rready_o = '0;
    for (int i = 0; i < NR_READ_PORTS; i++) begin
      rdata_o[i]  = mem_r[raddr_i[i]];
      rready_o[i] = ~pending_r[raddr_i[i]];
`ifdef REGFILE_BYPASS_EN
      // reg_we_s already excludes a hardwired register 0.
      if (reg_we_s[raddr_i[i]]) begin
        rdata_o[i]  = reg_wdata_s[raddr_i[i]];
        rready_o[i] = 1'b1;
      end else begin
        rdata_o[i]  = rdata_o[i];
      end
`endif
      if (ZERO_EN && (raddr_i[i] == '0)) begin
        rdata_o[i]  = '0;
        rready_o[i] = 1'b1;
      end else begin
        rready_o[i] = rready_o[i];
      end
    end
  end

  // Register storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned r = 32'd0; r < NR_REGS; r++) begin
        mem_r[r] <= '0;
      end
    end else begin
      for (int unsigned r = 32'd0; r < NR_REGS; r++) begin
        if (reg_we_s[r]) begin
          mem_r[r] <= reg_wdata_s[r];
        end else begin
          mem_r[r] <= mem_r[r];
        end
      end
    end
  end

  // Scoreboard state, pending count and conflict pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_r     <= '0;
      pending_cnt_r <= '0;
      wr_conflict_r <= 1'b0;
    end else begin
      pending_r     <= pending_nxt_s;
      pending_cnt_r <= cnt_nxt_s;
      wr_conflict_r <= conflict_s;
    end
  end

  assign pending_cnt_o = pending_cnt_r;
  assign wr_conflict_o = wr_conflict_r;

endmodule

// File: tb/tb_ariane_regfile_sb.sv
// tb_ariane_regfile_sb
// Directed scoreboard bench for ariane_regfile_sb in its default
// configuration. Stimulus pushes expected output values into a queue; a
// monitor on the falling clock edge pops and compares them against the DUT.
module tb_ariane_regfile_sb;
  import ariane_regfile_pkg::*;

  localparam int DW  = 64;
  localparam int NR  = 32;
  localparam int NRP = 2;
  localparam int NWP = 2;
  localparam int AW  = 5;
  localparam int CW  = 6;

  localparam int K_RDATA  = 0;
  localparam int K_RREADY = 1;
  localparam int K_CNT    = 2;
  localparam int K_CONF   = 3;
  localparam int K_AREADY = 4;

  typedef struct {
    string       name;
    int          kind;
    int          port;
    logic [63:0] val;
  } exp_t;

  logic                     clk;
  logic                     rst_ni;
  logic                     flush;
  logic [NRP-1:0][AW-1:0]   raddr;
  logic [NRP-1:0][DW-1:0]   rdata;
  logic [NRP-1:0]           rready;
  logic                     alloc_valid;
  regaddr_t                 alloc_addr;
  logic                     alloc_ready;
  logic [NWP-1:0][AW-1:0]   waddr;
  logic [NWP-1:0][DW-1:0]   wdata;
  logic [NWP-1:0]           we;
  logic [CW-1:0]            pending_cnt;
  logic                     wr_conflict;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  ariane_regfile_sb #(
    .DATA_WIDTH     (DW),
    .NR_REGS        (NR),
    .NR_READ_PORTS  (NRP),
    .NR_WRITE_PORTS (NWP),
    .ZERO_REG_ZERO  (1)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .flush_i       (flush),
    .raddr_i       (raddr),
    .rdata_o       (rdata),
    .rready_o      (rready),
    .alloc_valid_i (alloc_valid),
    .alloc_addr_i  (alloc_addr),
    .alloc_ready_o (alloc_ready),
    .waddr_i       (waddr),
    .wdata_i       (wdata),
    .we_i          (we),
    .pending_cnt_o (pending_cnt),
    .wr_conflict_o (wr_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push_exp(input string name, input int kind, input int port,
                          input logic [63:0] val);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.port = port;
    e.val  = val;
    q.push_back(e);
  endtask

  task automatic idle();
    flush       = 1'b0;
    alloc_valid = 1'b0;
    we          = '0;
    wdata       = '0;
    waddr       = '0;
  endtask

  // Advance past the next rising edge and release all strobes.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr(input int port, input int addr, input logic [63:0] d);
    we[port]    = 1'b1;
    waddr[port] = AW'(addr);
    wdata[port] = d;
  endtask

  task automatic alloc(input int addr);
    alloc_valid = 1'b1;
    alloc_addr  = AW'(addr);
  endtask

  // Monitor: compare every queued expectation against the settled outputs.
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [63:0] act;
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.kind)
        K_RDATA:  act = rdata[e.port];
        K_RREADY: act = 64'(rready[e.port]);
        K_CNT:    act = 64'(pending_cnt);
        K_CONF:   act = 64'(wr_conflict);
        K_AREADY: act = 64'(alloc_ready);
        default:  act = 'x;
      endcase
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", e.name, act, e.val);
      end
    end
  end

  initial begin
    rst_ni     = 1'b0;
    raddr      = '0;
    alloc_addr = '0;
    idle();
    @(posedge clk);
    #1;
    push_exp("rst_cnt", K_CNT, 0, 64'd0);
    push_exp("rst_conf", K_CONF, 0, 64'd0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;

    // Every register reads zero and ready after reset.
    for (int r = 0; r < NR; r += 2) begin
      step();
      raddr[0] = AW'(r);
      raddr[1] = AW'(r + 1);
      push_exp("rst_rdata0", K_RDATA, 0, 64'd0);
      push_exp("rst_rdata1", K_RDATA, 1, 64'd0);
      push_exp("rst_rready0", K_RREADY, 0, 64'd1);
      push_exp("rst_rready1", K_RREADY, 1, 64'd1);
      push_exp("rst_cnt_idle", K_CNT, 0, 64'd0);
    end

    // Allocate x5, observe pending, write it back.
    step();
    alloc(5);
    push_exp("a5_ready", K_AREADY, 0, 64'd1);
    step();
    raddr[0] = 5'd5;
    push_exp("x5_pending_rready", K_RREADY, 0, 64'd0);
    push_exp("x5_pending_cnt", K_CNT, 0, 64'd1);
    push_exp("x5_realloc_ready", K_AREADY, 0, 64'd0);
    step();
    wr(0, 5, 64'hDEAD);
`ifdef REGFILE_BYPASS_EN
    push_exp("x5_wb_rdata", K_RDATA, 0, 64'hDEAD);
    push_exp("x5_wb_rready", K_RREADY, 0, 64'd1);
`else
    push_exp("x5_wb_rdata", K_RDATA, 0, 64'd0);
    push_exp("x5_wb_rready", K_RREADY, 0, 64'd0);
`endif
    push_exp("x5_waw_stall", K_AREADY, 0, 64'd0);
    step();
    push_exp("x5_rdata", K_RDATA, 0, 64'hDEAD);
    push_exp("x5_rready", K_RREADY, 0, 64'd1);
    push_exp("x5_cnt", K_CNT, 0, 64'd0);
    push_exp("x5_alloc_ready", K_AREADY, 0, 64'd1);

    // Two ports write x7 together: higher port wins, one-cycle conflict.
    step();
    wr(0, 7, 64'h11);
    wr(1, 7, 64'h22);
    push_exp("conf_before", K_CONF, 0, 64'd0);
    step();
    raddr[0] = 5'd7;
    push_exp("x7_rdata", K_RDATA, 0, 64'h22);
    push_exp("conf_pulse", K_CONF, 0, 64'd1);
    step();
    push_exp("conf_after", K_CONF, 0, 64'd0);

    // Allocation against a pending register stalls, including the writeback cycle.
    step();
    alloc(3);
    push_exp("a3_ready", K_AREADY, 0, 64'd1);
    step();
    alloc(3);
    push_exp("a3_busy", K_AREADY, 0, 64'd0);
    push_exp("a3_cnt", K_CNT, 0, 64'd1);
    step();
    alloc(3);
    wr(1, 3, 64'h33);
    push_exp("a3_wb_stall", K_AREADY, 0, 64'd0);
    push_exp("a3_wb_cnt", K_CNT, 0, 64'd1);
    step();
    alloc(3);
    raddr[0] = 5'd3;
    push_exp("a3_retry_ready", K_AREADY, 0, 64'd1);
    push_exp("a3_retry_cnt", K_CNT, 0, 64'd0);
    push_exp("x3_rdata", K_RDATA, 0, 64'h33);
    step();
    push_exp("a3_realloc_cnt", K_CNT, 0, 64'd1);
    push_exp("x3_realloc_rready", K_RREADY, 0, 64'd0);
    push_exp("x3_realloc_rdata", K_RDATA, 0, 64'h33);
    step();
    wr(0, 3, 64'h34);
    step();
    push_exp("x3_clean_cnt", K_CNT, 0, 64'd0);

    // Flush with a concurrent write and a discarded allocation.
    step();
    alloc(1);
    step();
    alloc(2);
    step();
    alloc(4);
    step();
    flush = 1'b1;
    alloc(6);
    wr(0, 2, 64'h5);
    push_exp("flush_cnt_before", K_CNT, 0, 64'd3);
    push_exp("flush_aready", K_AREADY, 0, 64'd1);
    step();
    raddr[0] = 5'd2;
    raddr[1] = 5'd6;
    push_exp("flush_cnt_after", K_CNT, 0, 64'd0);
    push_exp("flush_x2_rdata", K_RDATA, 0, 64'h5);
    push_exp("flush_x2_rready", K_RREADY, 0, 64'd1);
    push_exp("flush_x6_rready", K_RREADY, 1, 64'd1);

    // Register 0: writes dropped, no conflict, allocation handshakes but sets nothing.
    step();
    wr(0, 0, 64'hFF);
    wr(1, 0, 64'hEE);
    alloc(0);
    raddr[0] = 5'd0;
    push_exp("x0_aready", K_AREADY, 0, 64'd1);
    push_exp("x0_wb_rdata", K_RDATA, 0, 64'd0);
    push_exp("x0_wb_rready", K_RREADY, 0, 64'd1);
    step();
    push_exp("x0_rdata", K_RDATA, 0, 64'd0);
    push_exp("x0_rready", K_RREADY, 0, 64'd1);
    push_exp("x0_cnt", K_CNT, 0, 64'd0);
    push_exp("x0_no_conf", K_CONF, 0, 64'd0);

    // Read x9 while it is being written.
    step();
    wr(1, 9, 64'h42);
    raddr[0] = 5'd9;
`ifdef REGFILE_BYPASS_EN
    push_exp("x9_wb_rdata", K_RDATA, 0, 64'h42);
`else
    push_exp("x9_wb_rdata", K_RDATA, 0, 64'd0);
`endif
    push_exp("x9_wb_rready", K_RREADY, 0, 64'd1);
    step();
    push_exp("x9_rdata", K_RDATA, 0, 64'h42);
    push_exp("x9_rready", K_RREADY, 0, 64'd1);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
